// File: rtl/valrdy_pkg.sv
// Shared types and helpers for the val/rdy deserializer.
package valrdy_pkg;

  typedef enum logic [0:0] {FILL, HOLD} deser_state_t;

  // Counter width for a slot count of n: at least one bit, even when n == 1.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/deser_slot_reg.sv
// One word slot of the deserializer: enabled load, async active-low clear.
module deser_slot_reg #(
  parameter int unsigned BIT_WIDTH = 32
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic                 en,
  input  logic [BIT_WIDTH-1:0] d,
  output logic [BIT_WIDTH-1:0] q
);

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset)  q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/valrdy_deserializer.sv
// Packs N_SAMPLES consecutive val/rdy words into one wide val/rdy frame.
module valrdy_deserializer
  import valrdy_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = 32,
  parameter int unsigned N_SAMPLES = 8
) (
  input  logic                           CLK,
  input  logic                           reset,
  input  logic                           snd_val,
  output logic                           snd_rdy,
  input  logic [BIT_WIDTH-1:0]           snd_msg,
  output logic                           rcv_val,
  input  logic                           rcv_rdy,
  output logic [BIT_WIDTH*N_SAMPLES-1:0] rcv_msg
);

  localparam int unsigned CW = cnt_width(N_SAMPLES);
  localparam logic [CW-1:0] LAST = CW'(N_SAMPLES - 1);

  deser_state_t  state, state_next;
  logic [CW-1:0] count, count_next;
  logic          fill_xfer;
  logic [BIT_WIDTH-1:0] slot_q [N_SAMPLES];

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state <= FILL;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  assign fill_xfer = (state == FILL) && snd_val;

  always_comb begin
    state_next = state;
    count_next = count;
    unique case (state)
      FILL: begin
        if (snd_val) begin
          if (count == LAST) begin
            state_next = HOLD;
            count_next = '0;
          end else begin
            count_next = count + 1'b1;
          end
        end
      end
      HOLD: begin
        if (rcv_rdy) state_next = FILL;
      end
      default: state_next = FILL;
    endcase
  end

  // State sits at FILL during reset, so gate with reset to keep snd_rdy low.
  assign snd_rdy = reset && (state == FILL);
  assign rcv_val = (state == HOLD);

  for (genvar i = 0; i < N_SAMPLES; i++) begin : g_slot
    deser_slot_reg #(
      .BIT_WIDTH(BIT_WIDTH)
    ) u_slot (
      .CLK   (CLK),
      .reset (reset),
      .en    (fill_xfer && (count == CW'(i))),
      .d     (snd_msg),
      .q     (slot_q[i])
    );
  end

  always_comb begin
    rcv_msg = '0;
    for (int unsigned i = 0; i < N_SAMPLES; i++) begin
      rcv_msg[i*BIT_WIDTH +: BIT_WIDTH] = slot_q[i];
    end
  end

endmodule

// File: tb/tb_valrdy_deserializer.sv
// Randomized self-checking bench for valrdy_deserializer (N=4 and N=1 instances).
module tb_valrdy_deserializer;

  localparam int unsigned BW = 32;
  localparam int unsigned N  = 4;
  localparam int unsigned FW = BW * N;

  logic          CLK;
  logic          reset;
  logic          snd_val, snd_rdy, rcv_val, rcv_rdy;
  logic [BW-1:0] snd_msg;
  logic [FW-1:0] rcv_msg;

  logic          d1_snd_val, d1_snd_rdy, d1_rcv_val, d1_rcv_rdy;
  logic [BW-1:0] d1_snd_msg, d1_rcv_msg;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: a queue of accepted words and the frame on offer.
  logic [BW-1:0] m_words[$];
  logic          m_hold;
  logic [FW-1:0] m_frame;

  valrdy_deserializer #(.BIT_WIDTH(BW), .N_SAMPLES(N)) dut (
    .CLK(CLK), .reset(reset),
    .snd_val(snd_val), .snd_rdy(snd_rdy), .snd_msg(snd_msg),
    .rcv_val(rcv_val), .rcv_rdy(rcv_rdy), .rcv_msg(rcv_msg)
  );

  valrdy_deserializer #(.BIT_WIDTH(BW), .N_SAMPLES(1)) dut1 (
    .CLK(CLK), .reset(reset),
    .snd_val(d1_snd_val), .snd_rdy(d1_snd_rdy), .snd_msg(d1_snd_msg),
    .rcv_val(d1_rcv_val), .rcv_rdy(d1_rcv_rdy), .rcv_msg(d1_rcv_msg)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic model_reset();
    m_words.delete();
    m_hold  = 1'b0;
    m_frame = '0;
  endtask

  // Drive one cycle from a negedge, advance the model, return on the next negedge.
  task automatic step(input logic v, input logic [BW-1:0] w, input logic r);
    snd_val = v;
    snd_msg = w;
    rcv_rdy = r;
    if (!m_hold) begin
      if (v) begin
        m_words.push_back(w);
        if (m_words.size() == N) begin
          m_frame = '0;
          for (int i = 0; i < N; i++) m_frame[i*BW +: BW] = m_words[i];
          m_words.delete();
          m_hold = 1'b1;
        end
      end
    end else if (r) begin
      m_hold = 1'b0;
    end
    @(negedge CLK);
  endtask

  task automatic test_reset();
    #1;
    n_cmp++; if (snd_rdy !== 1'b0) begin n_err++; $display("FAIL reset_snd_rdy got %b want 0", snd_rdy); end
    n_cmp++; if (rcv_val !== 1'b0) begin n_err++; $display("FAIL reset_rcv_val got %b want 0", rcv_val); end
    n_cmp++; if (rcv_msg !== '0) begin n_err++; $display("FAIL reset_rcv_msg got %h want 0", rcv_msg); end
    n_cmp++; if (d1_snd_rdy !== 1'b0) begin n_err++; $display("FAIL reset_d1_snd_rdy got %b want 0", d1_snd_rdy); end
    @(negedge CLK);
    reset = 1'b1;
    model_reset();
    #1;
    n_cmp++; if (snd_rdy !== 1'b1) begin n_err++; $display("FAIL release_snd_rdy got %b want 1", snd_rdy); end
    n_cmp++; if (rcv_val !== 1'b0) begin n_err++; $display("FAIL release_rcv_val got %b want 0", rcv_val); end
    @(negedge CLK);
  endtask

  task automatic test_basic();
    logic [BW-1:0] w [4];
    w[0] = 32'h11; w[1] = 32'h22; w[2] = 32'h33; w[3] = 32'h44;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (snd_rdy !== 1'b1) begin n_err++; $display("FAIL basic_snd_rdy[%0d] got %b want 1", i, snd_rdy); end
      n_cmp++; if (rcv_val !== 1'b0) begin n_err++; $display("FAIL basic_rcv_val_low[%0d] got %b want 0", i, rcv_val); end
      step(1'b1, w[i], 1'b1);
    end
    n_cmp++; if (rcv_val !== 1'b1) begin n_err++; $display("FAIL basic_rcv_val got %b want 1", rcv_val); end
    n_cmp++; if (snd_rdy !== 1'b0) begin n_err++; $display("FAIL basic_hold_snd_rdy got %b want 0", snd_rdy); end
    n_cmp++; if (rcv_msg !== 128'h00000044_00000033_00000022_00000011) begin
      n_err++; $display("FAIL basic_frame got %h want 00000044000000330000002200000011", rcv_msg); end
    step(1'b0, '0, 1'b1);
    n_cmp++; if (snd_rdy !== 1'b1) begin n_err++; $display("FAIL basic_resume_snd_rdy got %b want 1", snd_rdy); end
    n_cmp++; if (rcv_val !== 1'b0) begin n_err++; $display("FAIL basic_resume_rcv_val got %b want 0", rcv_val); end
  endtask

  task automatic test_backpressure();
    logic [FW-1:0] held;
    for (int i = 0; i < N; i++) step(1'b1, $urandom, 1'b0);
    held = rcv_msg;
    n_cmp++; if (held !== m_frame) begin n_err++; $display("FAIL bp_frame got %h want %h", held, m_frame); end
    for (int i = 0; i < 5; i++) begin
      step(1'b1, $urandom, 1'b0);
      n_cmp++; if (rcv_val !== 1'b1) begin n_err++; $display("FAIL bp_rcv_val[%0d] got %b want 1", i, rcv_val); end
      n_cmp++; if (snd_rdy !== 1'b0) begin n_err++; $display("FAIL bp_snd_rdy[%0d] got %b want 0", i, snd_rdy); end
      n_cmp++; if (rcv_msg !== m_frame) begin n_err++; $display("FAIL bp_hold[%0d] got %h want %h", i, rcv_msg, m_frame); end
    end
    step(1'b0, '0, 1'b1);
    n_cmp++; if (snd_rdy !== 1'b1) begin n_err++; $display("FAIL bp_release_snd_rdy got %b want 1", snd_rdy); end
    n_cmp++; if (rcv_val !== 1'b0) begin n_err++; $display("FAIL bp_release_rcv_val got %b want 0", rcv_val); end
  endtask

  task automatic test_bubbles();
    logic          pat [7];
    logic [BW-1:0] w [4];
    logic [FW-1:0] exp_frame;
    int            k;
    pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) w[i] = $urandom;
    exp_frame = {w[3], w[2], w[1], w[0]};
    k = 0;
    for (int i = 0; i < 7; i++) begin
      n_cmp++; if (rcv_val !== 1'b0) begin n_err++; $display("FAIL bubble_rcv_val_early[%0d] got %b want 0", i, rcv_val); end
      if (pat[i]) begin
        step(1'b1, w[k], 1'b1);
        k++;
      end else begin
        step(1'b0, $urandom, 1'b1);
      end
    end
    n_cmp++; if (rcv_val !== 1'b1) begin n_err++; $display("FAIL bubble_rcv_val got %b want 1", rcv_val); end
    n_cmp++; if (rcv_msg !== exp_frame) begin n_err++; $display("FAIL bubble_frame got %h want %h", rcv_msg, exp_frame); end
    step(1'b0, '0, 1'b1);
  endtask

  task automatic test_reset_mid_frame();
    step(1'b1, 32'hA, 1'b1);
    step(1'b1, 32'hB, 1'b1);
    reset   = 1'b0;
    snd_val = 1'b0;
    model_reset();
    @(negedge CLK);
    reset = 1'b1;
    for (int i = 1; i <= 4; i++) step(1'b1, BW'(i), 1'b0);
    n_cmp++; if (rcv_val !== 1'b1) begin n_err++; $display("FAIL midreset_rcv_val got %b want 1", rcv_val); end
    n_cmp++; if (rcv_msg !== {32'h4, 32'h3, 32'h2, 32'h1}) begin
      n_err++; $display("FAIL midreset_frame got %h want 00000004000000030000000200000001", rcv_msg); end
  endtask

  task automatic test_reset_in_hold();
    n_cmp++; if (rcv_val !== 1'b1) begin n_err++; $display("FAIL holdreset_pre_val got %b want 1", rcv_val); end
    #2;
    reset   = 1'b0;
    snd_val = 1'b0;
    #1;
    n_cmp++; if (rcv_val !== 1'b0) begin n_err++; $display("FAIL holdreset_rcv_val got %b want 0", rcv_val); end
    n_cmp++; if (rcv_msg !== '0) begin n_err++; $display("FAIL holdreset_rcv_msg got %h want 0", rcv_msg); end
    n_cmp++; if (snd_rdy !== 1'b0) begin n_err++; $display("FAIL holdreset_snd_rdy got %b want 0", snd_rdy); end
    @(negedge CLK);
    reset = 1'b1;
    model_reset();
    #1;
    n_cmp++; if (snd_rdy !== 1'b1) begin n_err++; $display("FAIL holdreset_release_snd_rdy got %b want 1", snd_rdy); end
    @(negedge CLK);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
      n_cmp++; if (snd_rdy !== !m_hold) begin n_err++; $display("FAIL rand_snd_rdy[%0d] got %b want %b", i, snd_rdy, !m_hold); end
      n_cmp++; if (rcv_val !== m_hold) begin n_err++; $display("FAIL rand_rcv_val[%0d] got %b want %b", i, rcv_val, m_hold); end
      if (m_hold) begin
        n_cmp++; if (rcv_msg !== m_frame) begin n_err++; $display("FAIL rand_frame[%0d] got %h want %h", i, rcv_msg, m_frame); end
      end
    end
    while (m_hold) step(1'b0, '0, 1'b1);
  endtask

  task automatic test_degenerate();
    logic [BW-1:0] w [3];
    w[0] = 32'd5; w[1] = 32'd6; w[2] = 32'd7;
    d1_rcv_rdy = 1'b1;
    for (int i = 0; i <= 6; i++) begin
      if (i % 2 == 0) begin
        n_cmp++; if (d1_snd_rdy !== 1'b1) begin n_err++; $display("FAIL n1_snd_rdy[%0d] got %b want 1", i, d1_snd_rdy); end
        n_cmp++; if (d1_rcv_val !== 1'b0) begin n_err++; $display("FAIL n1_rcv_val[%0d] got %b want 0", i, d1_rcv_val); end
      end else begin
        n_cmp++; if (d1_snd_rdy !== 1'b0) begin n_err++; $display("FAIL n1_snd_rdy[%0d] got %b want 0", i, d1_snd_rdy); end
        n_cmp++; if (d1_rcv_val !== 1'b1) begin n_err++; $display("FAIL n1_rcv_val[%0d] got %b want 1", i, d1_rcv_val); end
        n_cmp++; if (d1_rcv_msg !== w[(i-1)/2]) begin
          n_err++; $display("FAIL n1_msg[%0d] got %h want %h", i, d1_rcv_msg, w[(i-1)/2]); end
      end
      if (i < 6) begin
        d1_snd_val = 1'b1;
        d1_snd_msg = w[i/2];
        @(negedge CLK);
      end
    end
    d1_snd_val = 1'b0;
  endtask

  initial begin
    reset      = 1'b0;
    snd_val    = 1'b0;
    snd_msg    = '0;
    rcv_rdy    = 1'b0;
    d1_snd_val = 1'b0;
    d1_snd_msg = '0;
    d1_rcv_rdy = 1'b0;
    model_reset();
    test_reset();
    test_basic();
    test_backpressure();
    test_bubbles();
    test_reset_mid_frame();
    test_reset_in_hold();
    test_random();
    test_degenerate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
